// File: rtl/lc3b_cache_pkg.sv
// Shared types for the LC-3b direct-mapped cache: line/offset types, the
// cache FSM state encoding and a helper that locates a word inside a line.
package lc3b_cache_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [1:0]   lc3b_mem_wmask;
    typedef logic [127:0] lc3b_line;
    typedef logic [2:0]   lc3b_c_offset;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } cache_state_e;

    localparam int LINE_BYTES_LOG2 = 4;

    // Bit position of the least significant bit of word 'off' within a line.
    function automatic logic [6:0] word_lsb(input lc3b_c_offset off);
        return {off, 4'b0000};
    endfunction

endpackage

// File: rtl/lc3b_cache_control.sv
// Cache controller FSM: decides hit response, writeback and allocate phases,
// and drives the physical-memory strobes from registered state only.
module cache_control
    import lc3b_cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic         hit,
    input  logic         valid,
    input  logic         dirty,
    input  logic         pmem_resp,
    output cache_state_e state,
    output logic         mem_resp,
    output logic         write_hit,
    output logic         miss_start,
    output logic         fill_en,
    output logic         pmem_read,
    output logic         pmem_write
);

    cache_state_e state_d, state_q;
    logic         pmem_read_d, pmem_read_q;
    logic         pmem_write_d, pmem_write_q;
    logic         request;

    assign request = mem_read | mem_write;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (request && !hit) begin
                    state_d = (valid && dirty) ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                if (pmem_resp) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                if (pmem_resp) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        pmem_write_d = (state_d == S_WRITEBACK);
        pmem_read_d  = (state_d == S_ALLOCATE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
        end
    end

    // A request only completes from IDLE; the miss phases never respond.
    assign mem_resp   = (state_q == S_IDLE) && request && hit;
    assign write_hit  = mem_resp && mem_write;
    assign miss_start = (state_q == S_IDLE) && request && !hit;
    assign fill_en    = (state_q == S_ALLOCATE) && pmem_resp;
    assign state      = state_q;
    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;

endmodule

// File: rtl/lc3b_cache.sv
// Direct-mapped write-back, write-allocate cache between the LC-3b control
// FSM memory port and 128-bit-line physical memory.
module lc3b_cache
    import lc3b_cache_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 12 - IW;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_index;
    lc3b_c_offset  req_offset;
    logic          unused_addr_bit;

    assign req_tag         = mem_address[15:LINE_BYTES_LOG2+IW];
    assign req_index       = mem_address[LINE_BYTES_LOG2+IW-1:LINE_BYTES_LOG2];
    assign req_offset      = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    lc3b_line              data_d [NUM_SETS];
    lc3b_line              data_q [NUM_SETS];
    logic [TW-1:0]         tag_d  [NUM_SETS];
    logic [TW-1:0]         tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0]   valid_d, valid_q;
    logic [NUM_SETS-1:0]   dirty_d, dirty_q;
    logic [TW-1:0]         miss_tag_d, miss_tag_q;
    logic [IW-1:0]         miss_index_d, miss_index_q;

    cache_state_e state;
    logic         hit;
    logic         write_hit;
    logic         miss_start;
    logic         fill_en;
    lc3b_line     line_wr;

    assign hit = valid_q[req_index] && (tag_q[req_index] == req_tag);

    cache_control u_control (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .hit        (hit),
        .valid      (valid_q[req_index]),
        .dirty      (dirty_q[req_index]),
        .pmem_resp  (pmem_resp),
        .state      (state),
        .mem_resp   (mem_resp),
        .write_hit  (write_hit),
        .miss_start (miss_start),
        .fill_en    (fill_en),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write)
    );

    // Gating on hit keeps mem_rdata at zero out of reset and on misses.
    assign mem_rdata = hit ? data_q[req_index][word_lsb(req_offset) +: 16] : '0;

    always_comb begin
        line_wr = data_q[req_index];
        if (mem_byte_enable[0]) line_wr[word_lsb(req_offset) +: 8]        = mem_wdata[7:0];
        if (mem_byte_enable[1]) line_wr[word_lsb(req_offset) + 7'd8 +: 8] = mem_wdata[15:8];
    end

    always_comb begin
        data_d       = data_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        if (write_hit && (mem_byte_enable != 2'b00)) begin
            data_d[req_index]  = line_wr;
            dirty_d[req_index] = 1'b1;
        end
        // The missing line is captured once so pmem never sees mem_address live.
        if (miss_start) begin
            miss_tag_d   = req_tag;
            miss_index_d = req_index;
        end
        if (fill_en) begin
            data_d[miss_index_q]  = pmem_rdata;
            tag_d[miss_index_q]   = miss_tag_q;
            valid_d[miss_index_q] = 1'b1;
            dirty_d[miss_index_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
        end else begin
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
        end
    end

    // NOTE: line data and tags are storage qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state)
            S_WRITEBACK: begin
                pmem_address = {tag_q[miss_index_q], miss_index_q, 4'b0000};
                pmem_wdata   = data_q[miss_index_q];
            end
            S_ALLOCATE: begin
                pmem_address = {miss_tag_q, miss_index_q, 4'b0000};
            end
            default: begin
                pmem_address = '0;
                pmem_wdata   = '0;
            end
        endcase
    end

endmodule
